// File: rtl/mips_regfile_mp_if.sv
// Bus bundle for mips_regfile_mp: two write ports, packed read ports and the busy scoreboard.
// The master side is the datapath (writeback/decode); the slave side is the register file.
interface mips_regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                         wr_en_a;
    logic [ADDR_W-1:0]            wr_addr_a;
    logic [DATA_W-1:0]            wr_data_a;
    logic                         wr_en_b;
    logic [ADDR_W-1:0]            wr_addr_b;
    logic [DATA_W-1:0]            wr_data_b;
    logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
    logic [RD_PORTS*DATA_W-1:0]   rd_data;
    logic [RD_PORTS-1:0]          rd_busy;
    logic                         busy_set;
    logic [ADDR_W-1:0]            busy_addr;
    logic [NUM_REGS-1:0]          busy_vec;

    modport master (
        output wr_en_a, wr_addr_a, wr_data_a,
        output wr_en_b, wr_addr_b, wr_data_b,
        output rd_addr, busy_set, busy_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en_a, wr_addr_a, wr_data_a,
        input  wr_en_b, wr_addr_b, wr_data_b,
        input  rd_addr, busy_set, busy_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with a per-register busy scoreboard; r0 reads zero, never busy.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy clears) to the read ports.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    mips_regfile_mp_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] set_dec;
    logic [NUM_REGS-1:0] clr_dec;

    logic we_a;
    logic we_b;
    logic we_a_eff;

    // Writes to r0 are discarded; on an address collision port B (load) wins.
    assign we_a     = bus.wr_en_a && (bus.wr_addr_a != '0);
    assign we_b     = bus.wr_en_b && (bus.wr_addr_b != '0);
    assign we_a_eff = we_a && !(we_b && (bus.wr_addr_b == bus.wr_addr_a));

    // NOTE: reset clears every entry, so this array is built from flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (we_a_eff) regs[bus.wr_addr_a] <= bus.wr_data_a;
            if (we_b)     regs[bus.wr_addr_b] <= bus.wr_data_b;
        end
    end

    // Scoreboard: a new producer (set) outranks a retiring one (clear) on the same register.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        set_dec = '0;
        clr_dec = '0;
        if (bus.busy_set) set_dec[bus.busy_addr] = 1'b1;
        if (bus.wr_en_a)  clr_dec[bus.wr_addr_a] = 1'b1;
        if (bus.wr_en_b)  clr_dec[bus.wr_addr_b] = 1'b1;
        busy_nxt    = (busy_q & ~clr_dec) | set_dec;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign bus.busy_vec = busy_q;

    logic [ADDR_W-1:0]          ra [RD_PORTS];
    logic [RD_PORTS*DATA_W-1:0] rd_data_w;
    logic [RD_PORTS-1:0]        rd_busy_w;

    always_comb begin
        ra        = '{default: '0};
        rd_data_w = '0;
        rd_busy_w = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (ra[k] != '0) begin
                rd_data_w[k*DATA_W +: DATA_W] = regs[ra[k]];
                rd_busy_w[k]                  = busy_q[ra[k]];
`ifdef REGFILE_BYPASS_EN
                // Forwarding mirrors write priority; the busy flag drops unless re-set this cycle.
                if (!reset) begin
                    if (we_b && (bus.wr_addr_b == ra[k])) begin
                        rd_data_w[k*DATA_W +: DATA_W] = bus.wr_data_b;
                        rd_busy_w[k]                  = busy_q[ra[k]] & set_dec[ra[k]];
                    end else if (we_a && (bus.wr_addr_a == ra[k])) begin
                        rd_data_w[k*DATA_W +: DATA_W] = bus.wr_data_a;
                        rd_busy_w[k]                  = busy_q[ra[k]] & set_dec[ra[k]];
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: a spec-level model checked every cycle plus literal spot checks.
// Honours REGFILE_BYPASS_EN in both the model and the literal expectations.
module tb_mips_regfile_mp;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int RD_PORTS = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic clk;
    logic reset;
    logic checking;
    int   n_cmp;
    int   n_bad;

    mips_regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) bus ();

    mips_regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model state, updated from the rules of operation at each rising edge.
    logic [DATA_W-1:0] m_reg  [NUM_REGS];
    logic              m_busy [NUM_REGS];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_reg[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (bus.wr_en_a && bus.wr_addr_a != 0 &&
                !(bus.wr_en_b && bus.wr_addr_b == bus.wr_addr_a))
                m_reg[bus.wr_addr_a] <= bus.wr_data_a;
            if (bus.wr_en_b && bus.wr_addr_b != 0)
                m_reg[bus.wr_addr_b] <= bus.wr_data_b;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.busy_set && bus.busy_addr == r)
                    m_busy[r] <= 1'b1;
                else if ((bus.wr_en_a && bus.wr_addr_a == r) || (bus.wr_en_b && bus.wr_addr_b == r))
                    m_busy[r] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (checking) begin
            logic [NUM_REGS-1:0] exp_vec;
            logic [ADDR_W-1:0]   a;
            logic [DATA_W-1:0]   exp_d;
            logic                exp_b;
            for (int r = 0; r < NUM_REGS; r++) exp_vec[r] = m_busy[r];
            check("busy_vec", bus.busy_vec, exp_vec);
            for (int k = 0; k < RD_PORTS; k++) begin
                a     = bus.rd_addr[k*ADDR_W +: ADDR_W];
                exp_d = (a == 0) ? '0 : m_reg[a];
                exp_b = (a == 0) ? 1'b0 : m_busy[a];
                if (BYPASS && !reset && a != 0) begin
                    if (bus.wr_en_b && bus.wr_addr_b == a) begin
                        exp_d = bus.wr_data_b;
                        exp_b = m_busy[a] && bus.busy_set && bus.busy_addr == a;
                    end else if (bus.wr_en_a && bus.wr_addr_a == a) begin
                        exp_d = bus.wr_data_a;
                        exp_b = m_busy[a] && bus.busy_set && bus.busy_addr == a;
                    end
                end
                check($sformatf("model_rd_data[%0d]", k), bus.rd_data[k*DATA_W +: DATA_W], exp_d);
                check($sformatf("model_rd_busy[%0d]", k), bus.rd_busy[k], exp_b);
            end
        end
    end

    // Advance one cycle; inputs change 2 time units after the edge, enables default low.
    task automatic tick();
        @(posedge clk);
        #2;
        bus.wr_en_a  = 1'b0;
        bus.wr_en_b  = 1'b0;
        bus.busy_set = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rdd(input int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en_a = 1'b1; bus.wr_addr_a = a; bus.wr_data_a = d;
    endtask

    task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en_b = 1'b1; bus.wr_addr_b = a; bus.wr_data_b = d;
    endtask

    task automatic set_busy(input logic [ADDR_W-1:0] a);
        bus.busy_set = 1'b1; bus.busy_addr = a;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        checking = 1'b0;
        reset = 1'b1;
        bus.wr_en_a = 1'b0; bus.wr_addr_a = '0; bus.wr_data_a = '0;
        bus.wr_en_b = 1'b0; bus.wr_addr_b = '0; bus.wr_data_b = '0;
        bus.rd_addr = '0; bus.busy_set = 1'b0; bus.busy_addr = '0;

        tick();
        checking = 1'b1;
        reset = 1'b0;

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < NUM_REGS; a++) begin
            logic [ADDR_W-1:0] a5;
            a5 = ADDR_W'(a);
            set_rd(0, a5);
            set_rd(1, ~a5);
            #1;
            check("reset_rd0", rdd(0), 32'h0);
            check("reset_rd1", rdd(1), 32'h0);
            check("reset_busy", {62'b0, bus.rd_busy}, 64'h0);
            tick();
        end

        // Port A write, visible next cycle (same cycle only with bypass).
        wr_a(5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5);
        #1;
        check("r5_same_cycle", rdd(0), BYPASS ? 32'hDEADBEEF : 32'h0);
        tick();
        #1;
        check("r5_next_cycle", rdd(0), 32'hDEADBEEF);
        check("r5_not_busy", bus.rd_busy[0], 1'b0);

        // Write to r0 is discarded.
        wr_a(5'd0, 32'hFFFFFFFF);
        set_rd(1, 5'd0);
        tick();
        #1;
        check("r0_reads_zero", rdd(1), 32'h0);

        // Collision: port B wins.
        wr_a(5'd7, 32'h11111111);
        wr_b(5'd7, 32'h22222222);
        set_rd(0, 5'd7);
        tick();
        #1;
        check("r7_collision", rdd(0), 32'h22222222);

        // Scoreboard set, clear by write, set-beats-clear.
        set_busy(5'd9);
        set_rd(0, 5'd9);
        tick();
        #1;
        check("r9_busy_set", bus.rd_busy[0], 1'b1);
        check("r9_busy_vec", bus.busy_vec[9], 1'b1);
        wr_b(5'd9, 32'h5);
        tick();
        #1;
        check("r9_busy_cleared", bus.rd_busy[0], 1'b0);
        check("r9_data", rdd(0), 32'h5);
        set_busy(5'd9);
        tick();
        set_busy(5'd9);
        wr_a(5'd9, 32'h77);
        #1;
        check("r9_set_and_write_same_cycle", bus.rd_busy[0], 1'b1);
        tick();
        #1;
        check("r9_stays_busy", bus.rd_busy[0], 1'b1);
        check("r9_data_77", rdd(0), 32'h77);

        // busy_set on r0 ignored; two independent writes in one cycle.
        set_busy(5'd0);
        wr_a(5'd1, 32'hCAFE0001);
        wr_b(5'd2, 32'hCAFE0002);
        tick();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        check("busy_r0_ignored", bus.busy_vec[0], 1'b0);
        check("r1_port_a", rdd(0), 32'hCAFE0001);
        check("r2_port_b", rdd(1), 32'hCAFE0002);

        // Old value then new value on r3 (combinational with bypass).
        wr_a(5'd3, 32'h00000BAD);
        tick();
        wr_a(5'd3, 32'hA5A5A5A5);
        set_rd(1, 5'd3);
        #1;
        check("r3_same_cycle", rdd(1), BYPASS ? 32'hA5A5A5A5 : 32'h00000BAD);
        tick();
        #1;
        check("r3_next_cycle", rdd(1), 32'hA5A5A5A5);

        // Reset mid-operation drops the concurrent write and clears everything.
        wr_a(5'd10, 32'h1234);
        tick();
        set_busy(5'd10);
        set_rd(0, 5'd10);
        tick();
        #1;
        check("r10_data", rdd(0), 32'h1234);
        check("r10_busy", bus.rd_busy[0], 1'b1);
        reset = 1'b1;
        wr_b(5'd10, 32'h9);
        tick();
        reset = 1'b0;
        set_rd(1, 5'd5);
        #1;
        check("r10_after_reset", rdd(0), 32'h0);
        check("busy_vec_after_reset", bus.busy_vec, 32'h0);
        check("r5_after_reset", rdd(1), 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
